stream_trans: RTL and testbench
===============================

STREAM_TRANS -- requirements
Module: stream_trans

Interface
REQ-001 SHALL have parameter DATA_W, default 8, beat width in bits (legal 1..64).
REQ-002 SHALL have parameter DELAY, default 2, output latency in cycles from accepted beat to data_en (legal 1..8).
REQ-003 SHALL have parameter MARK_CNT, default 2, consecutive marker beats that terminate a frame (legal 1..15).
REQ-004 SHALL have parameter LEN_W, default 16, width of the frame length counter.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  beat strobe; input beat valid when 1.
REQ-008 SHALL have port byt  input  1  beat type: 1 = ordinary data, 0 = marker.
REQ-009 SHALL have port data_in  input  DATA_W  beat payload.
REQ-010 SHALL have port data_o  output  DATA_W  delayed ordinary payload.
REQ-011 SHALL have port data_en  output  1  data_o valid qualifier.
REQ-012 SHALL have port frame_end  output  1  one-cycle pulse marking frame termination.
REQ-013 SHALL have port frame_len  output  LEN_W  ordinary-beat count of the last completed frame.

Function
REQ-014 SHALL implement FSM states IDLE, XFER, MARK; start=0 holds state, marker count and frame counter unchanged in every state.
REQ-015 IDLE: start&byt -> XFER (beat accepted); start&~byt -> MARK with mark count 1 (MARK_CNT=1: frame_end, stay IDLE).
REQ-016 XFER: start&byt -> XFER (beat accepted); start&~byt -> MARK, mark count 1 (MARK_CNT=1: frame_end, -> IDLE).
REQ-017 MARK: start&~byt increments mark count; on reaching MARK_CNT -> IDLE and frame_end issued; start&byt -> XFER, beat accepted, mark count cleared.
REQ-018 Marker beats SHALL never appear on data_o/data_en; isolated markers below MARK_CNT are silently dropped.
REQ-019 Each accepted ordinary beat SHALL produce data_en=1 with its payload on data_o exactly DELAY cycles after the accepting edge; ordering preserved, no stalls, pipeline advances every cycle regardless of start.
REQ-020 frame_end SHALL pulse DELAY cycles after the terminating marker edge, aligned after the frame's last data_en.
REQ-021 When data_en=0, data_o SHALL hold its last value (no X on outputs).
REQ-022 Frame terminating with zero ordinary beats (markers only) SHALL still pulse frame_end, frame_len=0.

Reset
REQ-023 reset_n=0 SHALL immediately force state IDLE, mark count 0, pipeline valids 0, data_o=0, data_en=0, frame_end=0, frame_len=0.
REQ-024 Reset mid-frame SHALL discard all in-flight beats; no data_en or frame_end emitted for them after release.

Configuration
REQ-025 With macro STREAM_TRANS_LEN_EN defined, frame counter SHALL count accepted ordinary beats per frame, saturate at 2^LEN_W-1, and load frame_len in the same cycle frame_end pulses.
REQ-026 Without STREAM_TRANS_LEN_EN, counter logic SHALL be absent and frame_len tied to 0; all other behaviour identical.

Structure
REQ-027 Package stream_trans_pkg SHALL hold the state enum (IDLE/XFER/MARK) and parameter default constants.
REQ-028 The DELAY-stage valid/payload/frame_end shift register SHALL be sub-module trans_delay_line, parametrised by DATA_W and DELAY.

Verification
REQ-029 Defaults; start=1, byt=1, data 0x11,0x22,0x33 on cycles 0-2 -> data_en cycles 2-4, data_o 0x11,0x22,0x33.
REQ-030 Defaults; data 0xA5, marker, marker -> one data_en (0xA5), frame_end 2 cycles after second marker, frame_len=1 (LEN_EN).
REQ-031 Defaults; data 0x01, marker, data 0x02, start=0 for 3 cycles, data 0x03 -> data_en for 0x01,0x02,0x03 only, no frame_end.
REQ-032 MARK_CNT=1, DELAY=1; marker alone in IDLE -> frame_end next cycle, frame_len=0, no data_en.
REQ-033 LEN_W=2, LEN_EN; 5 data beats then 2 markers -> frame_len=3 (saturated).
REQ-034 Defaults; 2 data beats, reset_n low 1 cycle after second accept -> no data_en after reset, all outputs 0.

Source files
------------

// File: rtl/stream_trans_pkg.sv
// Shared types and default parameter values for the stream_trans frame translator.
package stream_trans_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        MARK = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DELAY    = 2;
    localparam int DEF_MARK_CNT = 2;
    localparam int DEF_LEN_W    = 16;
    localparam int MARK_W       = 4;

endpackage

// File: rtl/stream_trans_delay_line.sv
// Fixed-latency shift register carrying beat valid/payload and the frame_end/length tag.
module trans_delay_line #(
    parameter int DATA_W = 8,
    parameter int DELAY  = 2,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_end,
    input  logic [LEN_W-1:0]  in_len,
    output logic [DATA_W-1:0] data_o,
    output logic              data_en,
    output logic              frame_end,
    output logic [LEN_W-1:0]  frame_len
);

    for (genvar g = 0; g < DELAY; g++) begin : g_stage
        logic              valid_s;
        logic              end_s;
        logic [DATA_W-1:0] data_s;
        logic [LEN_W-1:0]  len_s;
        logic              valid_r;
        logic              end_r;
        logic [DATA_W-1:0] data_r;
        logic [LEN_W-1:0]  len_r;

        if (g == 0) begin : g_head
            assign valid_s = in_valid;
            assign end_s   = in_end;
            assign data_s  = in_data;
            assign len_s   = in_len;
        end else begin : g_link
            assign valid_s = g_stage[g-1].valid_r;
            assign end_s   = g_stage[g-1].end_r;
            assign data_s  = g_stage[g-1].data_r;
            assign len_s   = g_stage[g-1].len_r;
        end

        // Payload and length only move with their qualifier so the last stage holds its value.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_r <= 1'b0;
                end_r   <= 1'b0;
                data_r  <= {DATA_W{1'b0}};
                len_r   <= {LEN_W{1'b0}};
            end else begin
                valid_r <= valid_s;
                end_r   <= end_s;
                if (valid_s) begin
                    data_r <= data_s;
                end else begin
                    data_r <= data_r;
                end
                if (end_s) begin
                    len_r <= len_s;
                end else begin
                    len_r <= len_r;
                end
            end
        end
    end

    assign data_o    = g_stage[DELAY-1].data_r;
    assign data_en   = g_stage[DELAY-1].valid_r;
    assign frame_end = g_stage[DELAY-1].end_r;
    assign frame_len = g_stage[DELAY-1].len_r;

endmodule

// File: rtl/stream_trans.sv
// Frame translator: forwards ordinary beats with fixed latency and flags frame ends after MARK_CNT markers.
// Optional frame length counting is enabled by defining STREAM_TRANS_LEN_EN.
module stream_trans
    import stream_trans_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DELAY    = DEF_DELAY,
    parameter int MARK_CNT = DEF_MARK_CNT,
    parameter int LEN_W    = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              byt,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_o,
    output logic              data_en,
    output logic              frame_end,
    output logic [LEN_W-1:0]  frame_len
);

    localparam logic [MARK_W-1:0] MARK_LIM = MARK_W'(MARK_CNT);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [MARK_W-1:0]   mark_cnt_r;
    logic [MARK_W-1:0]   mark_nxt_s;
    logic [MARK_W-1:0]   mark_inc_s;
    logic                recover_s;
    logic                accept_s;
    logic                term_s;
    logic [LEN_W-1:0]    len_s;

    // State and marker-run registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            mark_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            mark_cnt_r <= mark_nxt_s;
        end
    end

    // Next-state logic: a marker extends the current run, a data beat always restarts XFER.
    always_comb begin
        state_nxt_s = state_r;
        mark_nxt_s  = mark_cnt_r;
        mark_inc_s  = 4'd1;
        recover_s   = 1'b0;
        accept_s    = 1'b0;
        term_s      = 1'b0;
        case (state_r)
            IDLE, XFER: mark_inc_s = 4'd1;
            MARK:       mark_inc_s = mark_cnt_r + 4'd1;
            default: begin
                mark_inc_s = 4'd1;
                recover_s  = 1'b1;
            end
        endcase
        if (start && byt) begin
            accept_s    = 1'b1;
            state_nxt_s = XFER;
            mark_nxt_s  = 4'd0;
        end else if (start) begin
            if (mark_inc_s == MARK_LIM) begin
                term_s      = 1'b1;
                state_nxt_s = IDLE;
                mark_nxt_s  = 4'd0;
            end else begin
                state_nxt_s = MARK;
                mark_nxt_s  = mark_inc_s;
            end
        end else begin
            if (recover_s) begin
                state_nxt_s = IDLE;
                mark_nxt_s  = 4'd0;
            end else begin
                state_nxt_s = state_r;
                mark_nxt_s  = mark_cnt_r;
            end
        end
    end

`ifdef STREAM_TRANS_LEN_EN
    logic [LEN_W-1:0] len_cnt_r;

    // Per-frame ordinary beat count, saturating; cleared once the frame terminates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_cnt_r <= {LEN_W{1'b0}};
        end else if (term_s) begin
            len_cnt_r <= {LEN_W{1'b0}};
        end else if (accept_s && (len_cnt_r != {LEN_W{1'b1}})) begin
            len_cnt_r <= len_cnt_r + LEN_W'(1);
        end else begin
            len_cnt_r <= len_cnt_r;
        end
    end

    assign len_s = len_cnt_r;
`else
    assign len_s = {LEN_W{1'b0}};
`endif

    trans_delay_line #(
        .DATA_W (DATA_W),
        .DELAY  (DELAY),
        .LEN_W  (LEN_W)
    ) u_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (accept_s),
        .in_data   (data_in),
        .in_end    (term_s),
        .in_len    (len_s),
        .data_o    (data_o),
        .data_en   (data_en),
        .frame_end (frame_end),
        .frame_len (frame_len)
    );

endmodule

// File: tb/tb_stream_trans.sv
// Self-checking bench for stream_trans: two configurations share one stimulus stream and
// are compared against an event-level reference model of frames, markers and latency.
module tb_stream_trans;

    typedef struct packed {
        logic [31:0] cyc;
        logic        is_end;
        logic [15:0] val;
    } ev_t;

    localparam int A_DELAY = 2, A_MARK = 2, A_LEN_W = 16;
    localparam int B_DELAY = 1, B_MARK = 1, B_LEN_W = 2;
`ifdef STREAM_TRANS_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        byt = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  a_do, b_do;
    logic        a_en, b_en, a_fe, b_fe;
    logic [15:0] a_fl;
    logic [1:0]  b_fl;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    ev_t exp_q[2][$];
    ev_t obs_q[2][$];
    int mk[2] = '{0, 0};
    int flen[2] = '{0, 0};
    int viol[2] = '{0, 0};
    logic [7:0]  last_d[2] = '{8'h00, 8'h00};
    logic [15:0] last_l[2] = '{16'h0, 16'h0};

    stream_trans #(.DATA_W(8), .DELAY(A_DELAY), .MARK_CNT(A_MARK), .LEN_W(A_LEN_W)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .byt(byt), .data_in(data_in),
        .data_o(a_do), .data_en(a_en), .frame_end(a_fe), .frame_len(a_fl));

    stream_trans #(.DATA_W(8), .DELAY(B_DELAY), .MARK_CNT(B_MARK), .LEN_W(B_LEN_W)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .byt(byt), .data_in(data_in),
        .data_o(b_do), .data_en(b_en), .frame_end(b_fe), .frame_len(b_fl));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(int c, logic e, logic [15:0] v);
        ev_t r;
        r.cyc = c;
        r.is_end = e;
        r.val = v;
        return r;
    endfunction

    // Observe output events and count hold violations (data_o / frame_len changing while unqualified).
    always @(negedge clk) begin
        if (!reset_n) begin
            last_d[0] <= 8'h00; last_d[1] <= 8'h00;
            last_l[0] <= 16'h0; last_l[1] <= 16'h0;
        end else begin
            if (a_en) obs_q[0].push_back(mk_ev(cyc, 1'b0, {8'h00, a_do}));
            else if (a_do !== last_d[0]) viol[0] <= viol[0] + 1;
            if (a_fe) obs_q[0].push_back(mk_ev(cyc, 1'b1, a_fl));
            else if (a_fl !== last_l[0]) viol[0] <= viol[0] + 1;
            if (b_en) obs_q[1].push_back(mk_ev(cyc, 1'b0, {8'h00, b_do}));
            else if (b_do !== last_d[1]) viol[1] <= viol[1] + 1;
            if (b_fe) obs_q[1].push_back(mk_ev(cyc, 1'b1, {14'h0, b_fl}));
            else if ({14'h0, b_fl} !== last_l[1]) viol[1] <= viol[1] + 1;
            last_d[0] <= a_do;
            last_d[1] <= b_do;
            last_l[0] <= a_fl;
            last_l[1] <= {14'h0, b_fl};
        end
    end

    // Reference model: a beat driven now is accepted on the next edge and shows up DELAY cycles later.
    function automatic void model(int k, bit s, bit b, logic [7:0] d);
        int dl, mc, mx;
        dl = (k == 0) ? A_DELAY : B_DELAY;
        mc = (k == 0) ? A_MARK : B_MARK;
        mx = (1 << ((k == 0) ? A_LEN_W : B_LEN_W)) - 1;
        if (!s) return;
        if (b) begin
            exp_q[k].push_back(mk_ev(cyc + dl, 1'b0, {8'h00, d}));
            if (flen[k] < mx) flen[k] = flen[k] + 1;
            mk[k] = 0;
        end else begin
            mk[k] = mk[k] + 1;
            if (mk[k] == mc) begin
                exp_q[k].push_back(mk_ev(cyc + dl, 1'b1, LEN_EN ? 16'(flen[k]) : 16'h0));
                mk[k] = 0;
                flen[k] = 0;
            end
        end
    endfunction

    task automatic drive(input bit s, input bit b, input logic [7:0] d);
        @(negedge clk);
        start = s;
        byt = b;
        data_in = d;
        model(0, s, b, d);
        model(1, s, b, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #3;
        total++;
        if ({a_do, a_en, a_fe, a_fl} !== 26'h0) begin
            bad++;
            $display("FAIL reset_a: got do=%h en=%b fe=%b fl=%h want all 0", a_do, a_en, a_fe, a_fl);
        end
        total++;
        if ({b_do, b_en, b_fe, b_fl} !== 12'h0) begin
            bad++;
            $display("FAIL reset_b: got do=%h en=%b fe=%b fl=%h want all 0", b_do, b_en, b_fe, b_fl);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_data_stream;
        drive(1'b1, 1'b1, 8'h11);
        drive(1'b1, 1'b1, 8'h22);
        drive(1'b1, 1'b1, 8'h33);
        idle(6);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                bad++;
                $display("FAIL data_stream dut%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                total++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    bad++;
                    $display("FAIL data_stream dut%0d ev%0d: got %0d/%b/%h want %0d/%b/%h", k, i,
                             obs_q[k][i].cyc, obs_q[k][i].is_end, obs_q[k][i].val,
                             exp_q[k][i].cyc, exp_q[k][i].is_end, exp_q[k][i].val);
                end
            end
            exp_q[k].delete();
            obs_q[k].delete();
        end
    endtask

    task automatic test_frame_end;
        drive(1'b1, 1'b1, 8'hA5);
        drive(1'b1, 1'b0, 8'h5A);
        drive(1'b1, 1'b0, 8'h77);
        idle(6);
        drive(1'b1, 1'b0, 8'h00);
        idle(6);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                bad++;
                $display("FAIL frame_end dut%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                total++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    bad++;
                    $display("FAIL frame_end dut%0d ev%0d: got %0d/%b/%h want %0d/%b/%h", k, i,
                             obs_q[k][i].cyc, obs_q[k][i].is_end, obs_q[k][i].val,
                             exp_q[k][i].cyc, exp_q[k][i].is_end, exp_q[k][i].val);
                end
            end
            exp_q[k].delete();
            obs_q[k].delete();
        end
    endtask

    task automatic test_dropped_marker;
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b0, 8'hEE);
        drive(1'b1, 1'b1, 8'h02);
        idle(3);
        drive(1'b1, 1'b1, 8'h03);
        idle(6);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'(8'h40 + i));
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        idle(6);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                bad++;
                $display("FAIL dropped_saturate dut%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                total++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    bad++;
                    $display("FAIL dropped_saturate dut%0d ev%0d: got %0d/%b/%h want %0d/%b/%h", k, i,
                             obs_q[k][i].cyc, obs_q[k][i].is_end, obs_q[k][i].val,
                             exp_q[k][i].cyc, exp_q[k][i].is_end, exp_q[k][i].val);
                end
            end
            exp_q[k].delete();
            obs_q[k].delete();
        end
    endtask

    task automatic test_reset_midframe;
        ev_t keep[$];
        drive(1'b1, 1'b1, 8'h9C);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h3D);
        drive(1'b1, 1'b1, 8'h4E);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            keep.delete();
            for (int i = 0; i < exp_q[k].size(); i++)
                if (exp_q[k][i].cyc < cyc) keep.push_back(exp_q[k][i]);
            exp_q[k] = keep;
            mk[k] = 0;
            flen[k] = 0;
        end
        #1;
        total++;
        if ({a_do, a_en, a_fe, a_fl, b_do, b_en, b_fe, b_fl} !== 38'h0) begin
            bad++;
            $display("FAIL reset_mid outputs: got a=%h/%b/%b/%h b=%h/%b/%b/%h want all 0",
                     a_do, a_en, a_fe, a_fl, b_do, b_en, b_fe, b_fl);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(8);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                bad++;
                $display("FAIL reset_mid dut%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                total++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    bad++;
                    $display("FAIL reset_mid dut%0d ev%0d: got %0d/%b/%h want %0d/%b/%h", k, i,
                             obs_q[k][i].cyc, obs_q[k][i].is_end, obs_q[k][i].val,
                             exp_q[k][i].cyc, exp_q[k][i].is_end, exp_q[k][i].val);
                end
            end
            exp_q[k].delete();
            obs_q[k].delete();
        end
        total++;
        if ({a_do, a_en, a_fe, a_fl} !== 26'h0) begin
            bad++;
            $display("FAIL reset_mid idle_a: got do=%h en=%b fe=%b fl=%h want all 0", a_do, a_en, a_fe, a_fl);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 600; n++)
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 2) != 0, 8'($urandom));
        idle(10);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                bad++;
                $display("FAIL random dut%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
            end
            for (int i = 0; i < exp_q[k].size() && i < obs_q[k].size(); i++) begin
                total++;
                if (obs_q[k][i] !== exp_q[k][i]) begin
                    bad++;
                    $display("FAIL random dut%0d ev%0d: got %0d/%b/%h want %0d/%b/%h", k, i,
                             obs_q[k][i].cyc, obs_q[k][i].is_end, obs_q[k][i].val,
                             exp_q[k][i].cyc, exp_q[k][i].is_end, exp_q[k][i].val);
                end
            end
            exp_q[k].delete();
            obs_q[k].delete();
            total++;
            if (viol[k] != 0) begin
                bad++;
                $display("FAIL hold dut%0d: got %0d unqualified output changes want 0", k, viol[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_stream();
        test_frame_end();
        test_dropped_marker();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
